mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline, directly downstream of the ALU (EX).

---
 rtl/mem_stage_pkg.sv | 51 +++++
 rtl/mem_access_stage_load_align.sv | 33 +++
 rtl/mem_access_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types, byte-enable masks and store-lane helpers for the MEM stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Size code 2'b11 is handled as a word access everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a[0];
      default: bad = |a;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = BE_BYTE0 << a;
      SZ_HALF: be = a[1] ? BE_HALF_HI : BE_HALF_LO;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane selection and sign/zero extension of a little-endian read word.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (size)
      SZ_BYTE: data = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: data = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: registers the EX result and runs one req/ack data-memory transaction.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        ctrl_mem_read,
  input  logic        ctrl_mem_write,
  input  logic [1:0]  ctrl_mem_size,
  input  logic        ctrl_mem_unsigned,
  input  logic        ctrl_reg_write,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        mem_err
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  mem_state_e  state, state_nxt;

  logic        accept, is_mem, misalign, start_mem, ack_done, timed_out;
  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_unsigned, lat_we, lat_reg_write;
  logic [4:0]  lat_rd;
  logic [31:0] load_data;

  assign ex_ready  = (state == ST_IDLE);
  assign dmem_req  = (state == ST_WAIT);
  assign accept    = ex_valid & ex_ready;
  assign is_mem    = ctrl_mem_read | ctrl_mem_write;
  assign misalign  = is_misaligned(ctrl_mem_size, alu_result[1:0]);
  assign start_mem = accept & is_mem & ~misalign;
  assign ack_done  = (state == ST_WAIT) & dmem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if (start_mem)
      wait_cnt <= '0;
    else if (state == ST_WAIT)
      wait_cnt <= wait_cnt + CW'(1);
  end

  // Fires on the edge closing the TIMEOUT_CYCLES-th WAIT cycle; an ack on that edge wins.
  assign timed_out = (state == ST_WAIT) & ~dmem_ack & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_mem) state_nxt = ST_WAIT;
      ST_WAIT: if (dmem_ack || timed_out) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .rdata       (dmem_rdata),
    .addr_lo     (lat_addr[1:0]),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .data        (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_addr      <= '0;
      lat_size      <= '0;
      lat_unsigned  <= 1'b0;
      lat_we        <= 1'b0;
      lat_reg_write <= 1'b0;
      lat_rd        <= '0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= '0;
      dmem_wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;

      if (accept) begin
        lat_addr      <= alu_result;
        lat_size      <= ctrl_mem_size;
        lat_unsigned  <= ctrl_mem_unsigned;
        lat_we        <= ctrl_mem_write;
        lat_reg_write <= ctrl_reg_write;
        lat_rd        <= rd;
        if (!is_mem) begin
          wb_valid     <= 1'b1;
          wb_data      <= alu_result;
          wb_rd        <= rd;
          wb_reg_write <= ctrl_reg_write;
        end else if (misalign) begin
          wb_valid     <= 1'b1;
          mem_err      <= 1'b1;
          wb_data      <= alu_result;
          wb_rd        <= rd;
          wb_reg_write <= 1'b0;
        end else begin
          dmem_we    <= ctrl_mem_write;
          dmem_addr  <= {alu_result[31:2], 2'b00};
          dmem_be    <= store_be(ctrl_mem_size, alu_result[1:0]);
          dmem_wdata <= store_lanes(ctrl_mem_size, store_data);
        end
      end

      if (ack_done) begin
        wb_valid     <= 1'b1;
        wb_data      <= lat_we ? lat_addr : load_data;
        wb_rd        <= lat_rd;
        wb_reg_write <= lat_reg_write & ~lat_we;
      end else if (timed_out) begin
        wb_valid     <= 1'b1;
        mem_err      <= 1'b1;
        wb_data      <= lat_addr;
        wb_rd        <= lat_rd;
        wb_reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (timeout case needs MEM_TIMEOUT_EN).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        ctrl_mem_read;
  logic        ctrl_mem_write;
  logic [1:0]  ctrl_mem_size;
  logic        ctrl_mem_unsigned;
  logic        ctrl_reg_write;
  logic [4:0]  rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        mem_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_valid          (ex_valid),
    .ex_ready          (ex_ready),
    .alu_result        (alu_result),
    .store_data        (store_data),
    .ctrl_mem_read     (ctrl_mem_read),
    .ctrl_mem_write    (ctrl_mem_write),
    .ctrl_mem_size     (ctrl_mem_size),
    .ctrl_mem_unsigned (ctrl_mem_unsigned),
    .ctrl_reg_write    (ctrl_reg_write),
    .rd                (rd),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_be           (dmem_be),
    .dmem_wdata        (dmem_wdata),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .wb_valid          (wb_valid),
    .wb_data           (wb_data),
    .wb_rd             (wb_rd),
    .wb_reg_write      (wb_reg_write),
    .mem_err           (mem_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid          = 1'b0;
    alu_result        = '0;
    store_data        = '0;
    ctrl_mem_read     = 1'b0;
    ctrl_mem_write    = 1'b0;
    ctrl_mem_size     = 2'b00;
    ctrl_mem_unsigned = 1'b0;
    ctrl_reg_write    = 1'b0;
    rd                = '0;
  endtask

  task automatic issue(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                       input logic uns, input logic rw, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] dst);
    ex_valid          = 1'b1;
    ctrl_mem_read     = rd_en;
    ctrl_mem_write    = wr_en;
    ctrl_mem_size     = sz;
    ctrl_mem_unsigned = uns;
    ctrl_reg_write    = rw;
    alu_result        = alu;
    store_data        = sd;
    rd                = dst;
  endtask

  // One-cycle-latency load: issue, observe request, ack with rdata, check WB.
  task automatic load_once(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] exp);
    issue(1'b1, 1'b0, sz, uns, 1'b1, addr, '0, 5'd7);
    tick();
    ex_idle();
    check_eq({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
    check_eq({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    tick();
    dmem_ack   = 1'b0;
    check_eq({tag, "_wbv"}, {31'b0, wb_valid}, 32'd1);
    check_eq({tag, "_data"}, wb_data, exp);
    check_eq({tag, "_req_drop"}, {31'b0, dmem_req}, 32'd0);
  endtask

  task automatic store_once(input string tag, input logic [1:0] sz, input logic rd_also,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(rd_also, 1'b1, sz, 1'b0, 1'b1, addr, sd, 5'd3);
    tick();
    ex_idle();
    check_eq({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
    check_eq({tag, "_we"}, {31'b0, dmem_we}, 32'd1);
    check_eq({tag, "_be"}, {28'b0, dmem_be}, {28'b0, exp_be});
    check_eq({tag, "_wdata"}, dmem_wdata, exp_wd);
    check_eq({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check_eq({tag, "_wbv"}, {31'b0, wb_valid}, 32'd1);
    check_eq({tag, "_wbrw"}, {31'b0, wb_reg_write}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ex_idle();
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    rst_n      = 1'b0;
    tick();
    tick();
    check_eq("rst_ready", {31'b0, ex_ready}, 32'd1);
    check_eq("rst_req", {31'b0, dmem_req}, 32'd0);
    check_eq("rst_wbv", {31'b0, wb_valid}, 32'd0);
    check_eq("rst_err", {31'b0, mem_err}, 32'd0);
    check_eq("rst_wbdata", wb_data, 32'd0);
    check_eq("rst_be", {28'b0, dmem_be}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU pass-through
    issue(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_002A, '0, 5'd5);
    tick();
    ex_idle();
    check_eq("alu_wbv", {31'b0, wb_valid}, 32'd1);
    check_eq("alu_data", wb_data, 32'h0000_002A);
    check_eq("alu_rd", {27'b0, wb_rd}, 32'd5);
    check_eq("alu_rw", {31'b0, wb_reg_write}, 32'd1);
    check_eq("alu_req", {31'b0, dmem_req}, 32'd0);
    check_eq("alu_ready", {31'b0, ex_ready}, 32'd1);
    tick();
    check_eq("alu_pulse", {31'b0, wb_valid}, 32'd0);

    load_once("lb",  2'b00, 1'b0, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80);
    check_eq("lb_rd", {27'b0, wb_rd}, 32'd7);
    check_eq("lb_rw", {31'b0, wb_reg_write}, 32'd1);
    load_once("lbu", 2'b00, 1'b1, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0080);
    load_once("lb1", 2'b00, 1'b0, 32'h0000_0101, 32'h80FF_1234, 32'h0000_0012);
    load_once("lh",  2'b01, 1'b0, 32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF);
    load_once("lhu", 2'b01, 1'b1, 32'h0000_0100, 32'h80FF_9234, 32'h0000_9234);
    load_once("lw",  2'b11, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    store_once("sh", 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    store_once("sb", 2'b00, 1'b0, 32'h0000_0301, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
    store_once("sw", 2'b10, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // Misaligned accesses
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_0201, '0, 5'd4);
    tick();
    ex_idle();
    check_eq("mis_w_req", {31'b0, dmem_req}, 32'd0);
    check_eq("mis_w_wbv", {31'b0, wb_valid}, 32'd1);
    check_eq("mis_w_err", {31'b0, mem_err}, 32'd1);
    check_eq("mis_w_rw", {31'b0, wb_reg_write}, 32'd0);
    check_eq("mis_w_ready", {31'b0, ex_ready}, 32'd1);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0203, 32'h1111, 5'd0);
    tick();
    ex_idle();
    check_eq("mis_h_req", {31'b0, dmem_req}, 32'd0);
    check_eq("mis_h_err", {31'b0, mem_err}, 32'd1);
    tick();
    check_eq("mis_err_pulse", {31'b0, mem_err}, 32'd0);

    // Stall: LW acked after 5 cycles while EX holds the next instruction
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_0300, '0, 5'd10);
    tick();
    issue(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_0055, '0, 5'd9);
    dmem_rdata = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_ready", {31'b0, ex_ready}, 32'd0);
      check_eq("stall_req", {31'b0, dmem_req}, 32'd1);
      check_eq("stall_wbv", {31'b0, wb_valid}, 32'd0);
      if (i == 4) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    check_eq("stall_ld_wbv", {31'b0, wb_valid}, 32'd1);
    check_eq("stall_ld_data", wb_data, 32'h1234_5678);
    check_eq("stall_ld_rd", {27'b0, wb_rd}, 32'd10);
    check_eq("stall_ready_back", {31'b0, ex_ready}, 32'd1);
    tick();
    ex_idle();
    check_eq("stall_next_wbv", {31'b0, wb_valid}, 32'd1);
    check_eq("stall_next_data", wb_data, 32'h0000_0055);
    check_eq("stall_next_rd", {27'b0, wb_rd}, 32'd9);

    // Ack while idle is ignored
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check_eq("idle_ack_wbv", {31'b0, wb_valid}, 32'd0);
    check_eq("idle_ack_req", {31'b0, dmem_req}, 32'd0);

    // Reset during WAIT, then a late ack
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_0500, '0, 5'd2);
    tick();
    ex_idle();
    check_eq("rstw_req", {31'b0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    check_eq("rstw_req_drop", {31'b0, dmem_req}, 32'd0);
    check_eq("rstw_wbv", {31'b0, wb_valid}, 32'd0);
    rst_n    = 1'b1;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check_eq("late_ack_wbv", {31'b0, wb_valid}, 32'd0);
    check_eq("late_ack_req", {31'b0, dmem_req}, 32'd0);
    check_eq("late_ack_ready", {31'b0, ex_ready}, 32'd1);

    // No ack at all
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_0600, '0, 5'd6);
    tick();
    ex_idle();
    for (int i = 0; i < 4; i++) begin
      check_eq("noack_req", {31'b0, dmem_req}, 32'd1);
      check_eq("noack_err", {31'b0, mem_err}, 32'd0);
      tick();
    end
`ifdef MEM_TIMEOUT_EN
    check_eq("to_req", {31'b0, dmem_req}, 32'd0);
    check_eq("to_wbv", {31'b0, wb_valid}, 32'd1);
    check_eq("to_err", {31'b0, mem_err}, 32'd1);
    check_eq("to_rw", {31'b0, wb_reg_write}, 32'd0);
    check_eq("to_ready", {31'b0, ex_ready}, 32'd1);
    tick();
    check_eq("to_pulse", {31'b0, wb_valid}, 32'd0);
`else
    tick();
    tick();
    check_eq("hold_req", {31'b0, dmem_req}, 32'd1);
    check_eq("hold_wbv", {31'b0, wb_valid}, 32'd0);
    check_eq("hold_ready", {31'b0, ex_ready}, 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_ack = 1'b0;
    check_eq("hold_wbv_end", {31'b0, wb_valid}, 32'd1);
    check_eq("hold_data", wb_data, 32'h0BAD_F00D);
    check_eq("hold_err", {31'b0, mem_err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
